mod_updown_counter: RTL and testbench

Parametrised modulo up/down counter, the successor to the fixed N-bit wrap-around up counter. It adds a run-time modulus, a direction select, a synchronous clear and load, count enable, and a one-shot/auto-reload mode. It sits in the sequential-logic library as the general timer/event-counter primitive for the workshop designs. `done` is a registered one-cycle pulse on every terminal step.

---
 rtl/mod_updown_counter_pkg.sv | 22 ++
 rtl/mod_updown_counter_if.sv | 28 ++
 rtl/mod_updown_counter_prescaler.sv | 41 ++++
 rtl/mod_updown_counter.sv | 99 +++++++++
 tb/tb_mod_updown_counter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_updown_counter_pkg.sv
// Shared types and constants for the modulo up/down counter family.
// Imported by the counter top and its optional prescaler.
package cnt_pkg;

    typedef enum logic {
        CNT_DOWN = 1'b0,
        CNT_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        CNT_WRAP    = 1'b0,
        CNT_ONESHOT = 1'b1
    } cnt_mode_e;

    localparam int CNT_MIN_WIDTH = 2;

    // Bits needed for a counter that must reach n-1; never less than one bit.
    function automatic int cnt_ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mod_updown_counter_if.sv
// Control/status bundle of the modulo up/down counter.
// The master drives the controls; the counter (slave) drives count_out/done/halted.
interface mod_updown_counter_if #(
    parameter int WIDTH = 8
);

    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             dir;
    logic             mode;
    logic [WIDTH-1:0] mod_val;
    logic [WIDTH-1:0] count_out;
    logic             done;
    logic             halted;

    modport master (
        output clr, load, load_val, en, dir, mode, mod_val,
        input  count_out, done, halted
    );

    modport slave (
        input  clr, load, load_val, en, dir, mode, mod_val,
        output count_out, done, halted
    );

endinterface

// File: rtl/mod_updown_counter_prescaler.sv
// Clock-enable divider: tick_o pulses on every PRESCALE-th cycle with en_i high.
// Only instantiated when CNT_PRESCALE_EN is defined.
module cnt_prescaler
    import cnt_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int PW = cnt_ctr_width(PRESCALE);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          last;

    assign last   = (pre_q == PW'(PRESCALE - 1));
    assign tick_o = en_i && last;

    always_comb begin
        pre_d = pre_q;
        if (clear_i) begin
            pre_d = '0;
        end else if (en_i) begin
            pre_d = last ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Modulo up/down counter: run-time modulus, direction, clear/load, one-shot or auto-reload.
// Define CNT_PRESCALE_EN to add a PRESCALE-cycle clock-enable divider ahead of the step logic.
module mod_updown_counter
    import cnt_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef CNT_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rstn,
    mod_updown_counter_if.slave  bus_io
);

    if (WIDTH < CNT_MIN_WIDTH) begin : gBadWidth
        $error("mod_updown_counter: WIDTH must be at least 2");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             done_q;
    logic             done_d;
    logic             halted_q;
    logic             halted_d;

    logic             step_en;
    logic             tick;
    logic             terminal;
    logic [WIDTH-1:0] step_val;

    assign step_en = bus_io.en && !halted_q;

`ifdef CNT_PRESCALE_EN
    cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (bus_io.clr || bus_io.load),
        .en_i    (step_en),
        .tick_o  (tick)
    );
`else
    assign tick = 1'b1;
`endif

    // Up uses >= so a count left above mod_val by a load or modulus change recovers on its next step.
    always_comb begin
        terminal = 1'b0;
        step_val = count_q;
        if (cnt_dir_e'(bus_io.dir) == CNT_UP) begin
            terminal = (count_q >= bus_io.mod_val);
            step_val = terminal ? '0 : count_q + WIDTH'(1);
        end else begin
            terminal = (count_q == '0);
            step_val = terminal ? bus_io.mod_val : count_q - WIDTH'(1);
        end
    end

    // A one-shot terminal step keeps the count where it is and freezes until clr or load.
    always_comb begin
        count_d  = count_q;
        done_d   = 1'b0;
        halted_d = halted_q;
        if (bus_io.clr) begin
            count_d  = '0;
            halted_d = 1'b0;
        end else if (bus_io.load) begin
            count_d  = bus_io.load_val;
            halted_d = 1'b0;
        end else if (step_en && tick) begin
            done_d = terminal;
            if (terminal && cnt_mode_e'(bus_io.mode) == CNT_ONESHOT) begin
                halted_d = 1'b1;
            end else begin
                count_d = step_val;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q  <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            done_q   <= done_d;
            halted_q <= halted_d;
        end
    end

    assign bus_io.count_out = count_q;
    assign bus_io.done      = done_q;
    assign bus_io.halted    = halted_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Self-checking bench for mod_updown_counter: directed scenarios plus randomized traffic
// compared against a behavioural model of the counting rules.
module tb_mod_updown_counter;

    localparam int WIDTH = 8;
`ifdef CNT_PRESCALE_EN
    localparam int PRE = 3;
`else
    localparam int PRE = 1;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;

    mod_updown_counter_if #(.WIDTH(WIDTH)) bus ();

`ifdef CNT_PRESCALE_EN
    mod_updown_counter #(.WIDTH(WIDTH), .PRESCALE(PRE)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus)
    );
`else
    mod_updown_counter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (bus)
    );
`endif

    always #5 clk = ~clk;

    // Reference model: count lives in 0..mod_val, stepping every PRE enabled cycles.
    typedef struct {
        int count;
        int pre;
        bit done;
        bit halted;
    } model_t;

    model_t m;

    function automatic model_t modelNext(input model_t cur, input bit clr, input bit load,
                                         input int ldv, input bit en, input bit up,
                                         input bit oneshot, input int modv);
        model_t nx;
        int     target;
        bit     term;
        nx      = cur;
        nx.done = 1'b0;
        if (clr) begin
            nx.count  = 0;
            nx.pre    = 0;
            nx.halted = 1'b0;
        end else if (load) begin
            nx.count  = ldv;
            nx.pre    = 0;
            nx.halted = 1'b0;
        end else if (en && !cur.halted) begin
            nx.pre = (cur.pre + 1) % PRE;
            if (nx.pre == 0) begin
                if (up) begin
                    term   = (cur.count >= modv);
                    target = term ? 0 : cur.count + 1;
                end else begin
                    term   = (cur.count == 0);
                    target = term ? modv : cur.count - 1;
                end
                nx.done = term;
                if (term && oneshot) nx.halted = 1'b1;
                else nx.count = target;
            end
        end
        return nx;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m <= '{0, 0, 1'b0, 1'b0};
        end else begin
            m <= modelNext(m, bus.clr, bus.load, int'(bus.load_val), bus.en, bus.dir,
                           bus.mode, int'(bus.mod_val));
        end
    end

    // Advance n rising edges and settle just after the last one.
    task automatic edgeWait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn         = 1'b0;
        bus.clr      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.en       = 1'b1;
        bus.dir      = 1'b1;
        bus.mode     = 1'b0;
        bus.mod_val  = 8'd5;
        edgeWait(2);
        testsRun++;
        if (bus.count_out !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_count: got %0d expected 0", bus.count_out);
        end
        testsRun++;
        if (bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_done: got %b expected 0", bus.done);
        end
        testsRun++;
        if (bus.halted !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_halted: got %b expected 0", bus.halted);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_wrap_up();
        int seq [6] = '{1, 2, 3, 4, 5, 0};
        for (int i = 0; i < 6; i++) begin
            edgeWait(PRE);
            testsRun++;
            if (bus.count_out !== 8'(seq[i])) begin
                testsFailed++;
                $display("[TB] FAIL wrap_up_count[%0d]: got %0d expected %0d", i, bus.count_out, seq[i]);
            end
            testsRun++;
            if (bus.done !== (i == 5)) begin
                testsFailed++;
                $display("[TB] FAIL wrap_up_done[%0d]: got %b expected %b", i, bus.done, (i == 5));
            end
        end
    endtask

    task automatic test_down_wrap();
        int seq [4] = '{1, 0, 9, 8};
        bus.load     = 1'b1;
        bus.load_val = 8'd2;
        bus.dir      = 1'b0;
        bus.mod_val  = 8'd9;
        bus.en       = 1'b1;
        edgeWait(1);
        testsRun++;
        if (bus.count_out !== 8'd2 || bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL down_load: got count %0d done %b expected 2 / 0", bus.count_out, bus.done);
        end
        bus.load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            edgeWait(PRE);
            testsRun++;
            if (bus.count_out !== 8'(seq[i]) || bus.done !== (i == 2)) begin
                testsFailed++;
                $display("[TB] FAIL down_wrap[%0d]: got count %0d done %b expected %0d / %b",
                         i, bus.count_out, bus.done, seq[i], (i == 2));
            end
        end
    endtask

    task automatic test_oneshot();
        int seq  [5] = '{1, 2, 3, 3, 3};
        bit dn   [5] = '{0, 0, 0, 1, 0};
        bit hlt  [5] = '{0, 0, 0, 1, 1};
        bus.clr     = 1'b1;
        bus.mode    = 1'b1;
        bus.mod_val = 8'd3;
        bus.dir     = 1'b1;
        bus.en      = 1'b1;
        edgeWait(1);
        bus.clr = 1'b0;
        testsRun++;
        if (bus.count_out !== 8'd0) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_clr: got %0d expected 0", bus.count_out);
        end
        for (int i = 0; i < 5; i++) begin
            edgeWait(PRE);
            testsRun++;
            if (bus.count_out !== 8'(seq[i]) || bus.done !== dn[i] || bus.halted !== hlt[i]) begin
                testsFailed++;
                $display("[TB] FAIL oneshot[%0d]: got count %0d done %b halted %b expected %0d / %b / %b",
                         i, bus.count_out, bus.done, bus.halted, seq[i], dn[i], hlt[i]);
            end
        end
        bus.load     = 1'b1;
        bus.load_val = 8'd0;
        edgeWait(1);
        testsRun++;
        if (bus.count_out !== 8'd0 || bus.halted !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_reload: got count %0d halted %b expected 0 / 0", bus.count_out, bus.halted);
        end
        bus.load = 1'b0;
        edgeWait(PRE);
        testsRun++;
        if (bus.count_out !== 8'd1 || bus.halted !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL oneshot_resume: got count %0d halted %b expected 1 / 0", bus.count_out, bus.halted);
        end
        bus.mode = 1'b0;
    endtask

    task automatic test_priority();
        bus.clr      = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 8'd7;
        bus.en       = 1'b1;
        edgeWait(1);
        testsRun++;
        if (bus.count_out !== 8'd0 || bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL clr_over_load: got count %0d done %b expected 0 / 0", bus.count_out, bus.done);
        end
        bus.clr      = 1'b0;
        bus.load_val = 8'd200;
        bus.mod_val  = 8'd10;
        bus.dir      = 1'b1;
        bus.mode     = 1'b0;
        edgeWait(1);
        testsRun++;
        if (bus.count_out !== 8'd200) begin
            testsFailed++;
            $display("[TB] FAIL load_over_en: got %0d expected 200", bus.count_out);
        end
        bus.load = 1'b0;
        edgeWait(PRE);
        testsRun++;
        if (bus.count_out !== 8'd0 || bus.done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL recover_range: got count %0d done %b expected 0 / 1", bus.count_out, bus.done);
        end
    endtask

    task automatic test_boundaries();
        bus.load     = 1'b1;
        bus.load_val = 8'd254;
        bus.mod_val  = 8'd255;
        bus.dir      = 1'b1;
        bus.mode     = 1'b0;
        bus.en       = 1'b1;
        edgeWait(1);
        bus.load = 1'b0;
        edgeWait(PRE);
        testsRun++;
        if (bus.count_out !== 8'd255 || bus.done !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL full_range_top: got count %0d done %b expected 255 / 0", bus.count_out, bus.done);
        end
        edgeWait(PRE);
        testsRun++;
        if (bus.count_out !== 8'd0 || bus.done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL full_range_wrap: got count %0d done %b expected 0 / 1", bus.count_out, bus.done);
        end
        bus.dir = 1'b0;
        edgeWait(PRE);
        testsRun++;
        if (bus.count_out !== 8'd255 || bus.done !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL full_range_down: got count %0d done %b expected 255 / 1", bus.count_out, bus.done);
        end
        bus.clr     = 1'b1;
        bus.mod_val = 8'd0;
        bus.dir     = 1'b1;
        edgeWait(1);
        bus.clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            edgeWait(PRE);
            testsRun++;
            if (bus.count_out !== 8'd0 || bus.done !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL mod_zero[%0d]: got count %0d done %b expected 0 / 1", i, bus.count_out, bus.done);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.clr     = 1'b1;
        bus.mod_val = 8'd9;
        bus.dir     = 1'b1;
        bus.mode    = 1'b0;
        bus.en      = 1'b1;
        edgeWait(1);
        bus.clr = 1'b0;
        edgeWait(4 * PRE);
        testsRun++;
        if (bus.count_out !== 8'd4) begin
            testsFailed++;
            $display("[TB] FAIL async_precount: got %0d expected 4", bus.count_out);
        end
        #2;
        rstn = 1'b0;
        #1;
        testsRun++;
        if (bus.count_out !== 8'd0 || bus.done !== 1'b0 || bus.halted !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got count %0d done %b halted %b expected 0 / 0 / 0",
                     bus.count_out, bus.done, bus.halted);
        end
        #1;
        rstn = 1'b1;
        edgeWait(PRE);
        testsRun++;
        if (bus.count_out !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL async_restart: got %0d expected 1", bus.count_out);
        end
    endtask

`ifdef CNT_PRESCALE_EN
    task automatic test_prescaler();
        int expA [3] = '{0, 0, 1};
        int expB [3] = '{1, 1, 2};
        bus.clr     = 1'b1;
        bus.en      = 1'b1;
        bus.mod_val = 8'd2;
        bus.dir     = 1'b1;
        bus.mode    = 1'b0;
        edgeWait(1);
        bus.clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            edgeWait(1);
            testsRun++;
            if (bus.count_out !== 8'(expA[i])) begin
                testsFailed++;
                $display("[TB] FAIL prescale_run[%0d]: got %0d expected %0d", i, bus.count_out, expA[i]);
            end
        end
        bus.en = 1'b0;
        edgeWait(2);
        testsRun++;
        if (bus.count_out !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL prescale_hold: got %0d expected 1", bus.count_out);
        end
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edgeWait(1);
            testsRun++;
            if (bus.count_out !== 8'(expB[i])) begin
                testsFailed++;
                $display("[TB] FAIL prescale_stretch[%0d]: got %0d expected %0d", i, bus.count_out, expB[i]);
            end
        end
    endtask
`endif

    // Each segment clears with a fresh modulus, then drives random controls every cycle.
    task automatic test_random();
        int modv;
        for (int seg = 0; seg < 12; seg++) begin
            modv = (seg == 0) ? 0 : (seg == 1) ? 255 : int'($urandom_range(1, 20));
            bus.mod_val = 8'(modv);
            for (int cyc = 0; cyc < 60; cyc++) begin
                bus.clr      = (cyc == 0) || ($urandom_range(0, 31) == 0);
                bus.load     = ($urandom_range(0, 15) == 0);
                bus.load_val = 8'($urandom_range(0, modv));
                bus.en       = ($urandom_range(0, 3) != 0);
                bus.dir      = 1'($urandom_range(0, 1));
                bus.mode     = ($urandom_range(0, 7) == 0);
                edgeWait(1);
                testsRun++;
                if (bus.count_out !== 8'(m.count)) begin
                    testsFailed++;
                    $display("[TB] FAIL random_count seg %0d cyc %0d: got %0d expected %0d",
                             seg, cyc, bus.count_out, m.count);
                end
                testsRun++;
                if (bus.done !== m.done) begin
                    testsFailed++;
                    $display("[TB] FAIL random_done seg %0d cyc %0d: got %b expected %b",
                             seg, cyc, bus.done, m.done);
                end
                testsRun++;
                if (bus.halted !== m.halted) begin
                    testsFailed++;
                    $display("[TB] FAIL random_halted seg %0d cyc %0d: got %b expected %b",
                             seg, cyc, bus.halted, m.halted);
                end
            end
        end
        bus.clr  = 1'b0;
        bus.load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_down_wrap();
        test_oneshot();
        test_priority();
        test_boundaries();
        test_async_reset();
`ifdef CNT_PRESCALE_EN
        test_prescaler();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
